// File: rtl/tlp_rxcpl_reorder.sv
// In-order read-completion return engine: replays buffered completions to the TXS slave in tag-issue order.
// Latency avail->first beat 3 cycles; ready low freezes the output beat, a 2-entry skid absorbs the in-flight read.
module tlp_rxcpl_reorder #(
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 128,
    parameter int SLOT_AW = 5,
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 50000
) (
    input  logic                     AvlClk_i,
    input  logic                     Rstn_i,
    input  logic                     TagIssue_i,
    input  logic                     CplReq_i,
    input  logic [TAG_W+1:0]         CplDesc_i,
    output logic [TAG_W+SLOT_AW-1:0] CplRdAddr_o,
    input  logic [DATA_W+1:0]        CplBufData_i,
    output logic [DATA_W-1:0]        TxsReadData_o,
    output logic                     TxsReadDataValid_o,
    output logic                     TxsReadErr_o,
    input  logic                     TxsReadReady_i,
    output logic                     TagRelease_o,
    output logic [TAG_W-1:0]         TagReleaseId_o,
    output logic                     UnexpCpl_o,
    output logic [TAG_W:0]           Outstanding_o
);
    localparam int NUM_TAGS = 1 << TAG_W;
    localparam int EW       = DATA_W + 2;
    localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(NUM_TAGS);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TMO_CYC - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_TMO    = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [TAG_W-1:0]    issue_ptr_q, issue_ptr_d;
    logic [TAG_W-1:0]    hol_q, hol_d;
    logic [NUM_TAGS-1:0] outst_q, outst_d;
    logic [NUM_TAGS-1:0] avail_q, avail_d;
    logic [NUM_TAGS-1:0] last_q, last_d;
    logic [TAG_W:0]      out_cnt_q, out_cnt_d;
    logic                cplreq_q, cplreq_d;
    logic [SLOT_AW-1:0]  beat_addr_q, beat_addr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                rd_vld_q, rd_vld_d;
    logic                eop_seen_q, eop_seen_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                rel_q, rel_d;
    logic [TAG_W-1:0]    rel_id_q, rel_id_d;
    logic                unexp_q, unexp_d;
    // entry layout: {err, eop, data}; entry 0 is the beat presented to the sink
    logic [EW-1:0]       ent_q [0:2];
    logic [EW-1:0]       ent_d [0:2];

    logic                rise, pop, done, retire, issue_ok, in_eop, space, rd_issue, push, tmo_clr;
    logic [TAG_W-1:0]    cpl_tag;
    logic [1:0]          wr_idx;
    logic [EW-1:0]       push_ent;
    logic                unused_rsvd;

    assign unused_rsvd = CplBufData_i[DATA_W];
    assign cpl_tag  = CplDesc_i[TAG_W-1:0];
    assign rise     = CplReq_i & ~cplreq_q & CplDesc_i[TAG_W];
    assign pop      = (cnt_q != 2'd0) & TxsReadReady_i;
    assign done     = pop & ent_q[0][DATA_W];
    assign retire   = done & ((state_q == ST_TMO) | last_q[hol_q]);
    assign issue_ok = TagIssue_i & (out_cnt_q != FULL_CNT);
    assign in_eop   = rd_vld_q & CplBufData_i[DATA_W+1];
    // a new read may only go out if its data is guaranteed a slot even if the sink stalls
    assign space    = ({1'b0, cnt_q} + {2'b0, rd_vld_q} + 3'd1) <= (3'd3 + {2'b0, pop});
    assign wr_idx   = cnt_q - {1'b0, pop};
    assign tmo_clr  = pop | retire | (rise & (cpl_tag == hol_q));

    always_comb begin
        state_d     = state_q;
        issue_ptr_d = issue_ptr_q;
        hol_d       = hol_q;
        outst_d     = outst_q;
        avail_d     = avail_q;
        last_d      = last_q;
        out_cnt_d   = out_cnt_q;
        cplreq_d    = CplReq_i;
        beat_addr_d = beat_addr_q;
        tmo_d       = tmo_q;
        eop_seen_d  = eop_seen_q;
        rel_d       = 1'b0;
        rel_id_d    = rel_id_q;
        unexp_d     = rise & ~outst_q[cpl_tag];
        rd_issue    = 1'b0;
        push        = 1'b0;
        push_ent    = '0;
        for (int i = 0; i < 3; i++) ent_d[i] = ent_q[i];

        if (rise & outst_q[cpl_tag]) begin
            avail_d[cpl_tag] = 1'b1;
            last_d[cpl_tag]  = CplDesc_i[TAG_W+1];
        end

        case (state_q)
            ST_IDLE: begin
                if (avail_q[hol_q]) begin
                    state_d     = ST_FETCH;
                    beat_addr_d = '0;
                    eop_seen_d  = 1'b0;
                end else if ((tmo_q == TMO_MAX) & outst_q[hol_q]) begin
                    state_d  = ST_TMO;
                    push     = 1'b1;
                    push_ent = {1'b1, 1'b1, {DATA_W{1'b0}}};
                end
            end
            ST_FETCH: begin
                rd_issue = 1'b1;
                state_d  = ST_STREAM;
            end
            ST_STREAM: begin
                rd_issue = ~eop_seen_q & ~in_eop & space;
                push     = rd_vld_q;
                push_ent = {1'b0, CplBufData_i[DATA_W+1], CplBufData_i[DATA_W-1:0]};
                if (in_eop) eop_seen_d = 1'b1;
                if (done) begin
                    avail_d[hol_q] = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                if (done) begin
                    avail_d[hol_q] = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
        endcase

        if (rd_issue) beat_addr_d = beat_addr_q + SLOT_AW'(1);

        if (pop) begin
            ent_d[0] = ent_q[1];
            ent_d[1] = ent_q[2];
        end
        if (push) begin
            case (wr_idx)
                2'd0:    ent_d[0] = push_ent;
                2'd1:    ent_d[1] = push_ent;
                default: ent_d[2] = push_ent;
            endcase
        end
        cnt_d = cnt_q - {1'b0, pop} + {1'b0, push};

        if (retire) begin
            outst_d[hol_q] = 1'b0;
            last_d[hol_q]  = 1'b0;
            hol_d          = hol_q + TAG_W'(1);
            rel_d          = 1'b1;
            rel_id_d       = hol_q;
        end
        // applied after retire so a same-index set wins
        if (issue_ok) begin
            outst_d[issue_ptr_q] = 1'b1;
            issue_ptr_d          = issue_ptr_q + TAG_W'(1);
        end
        out_cnt_d = out_cnt_q + (TAG_W+1)'(issue_ok) - (TAG_W+1)'(retire);

        if (tmo_clr) begin
            tmo_d = '0;
        end else if (outst_q[hol_q] & (state_q == ST_IDLE) & ~avail_q[hol_q] & (tmo_q != TMO_MAX)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge AvlClk_i or negedge Rstn_i) begin
        if (!Rstn_i) begin
            state_q     <= ST_IDLE;
            issue_ptr_q <= '0;
            hol_q       <= '0;
            outst_q     <= '0;
            avail_q     <= '0;
            last_q      <= '0;
            out_cnt_q   <= '0;
            cplreq_q    <= 1'b0;
            beat_addr_q <= '0;
            tmo_q       <= '0;
            rd_vld_q    <= 1'b0;
            eop_seen_q  <= 1'b0;
            cnt_q       <= '0;
            rel_q       <= 1'b0;
            rel_id_q    <= '0;
            unexp_q     <= 1'b0;
            ent_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            issue_ptr_q <= issue_ptr_d;
            hol_q       <= hol_d;
            outst_q     <= outst_d;
            avail_q     <= avail_d;
            last_q      <= last_d;
            out_cnt_q   <= out_cnt_d;
            cplreq_q    <= cplreq_d;
            beat_addr_q <= beat_addr_d;
            tmo_q       <= tmo_d;
            rd_vld_q    <= rd_issue;
            eop_seen_q  <= eop_seen_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            rel_id_q    <= rel_id_d;
            unexp_q     <= unexp_d;
            ent_q       <= ent_d;
        end
    end

    assign rd_vld_d           = rd_issue;
    assign CplRdAddr_o        = {hol_q, beat_addr_q};
    assign TxsReadData_o      = ent_q[0][DATA_W-1:0];
    assign TxsReadErr_o       = ent_q[0][DATA_W+1];
    assign TxsReadDataValid_o = (cnt_q != 2'd0);
    assign TagRelease_o       = rel_q;
    assign TagReleaseId_o     = rel_id_q;
    assign UnexpCpl_o         = unexp_q;
    assign Outstanding_o      = out_cnt_q;

endmodule

// File: tb/tb_tlp_rxcpl_reorder.sv
// Scoreboard bench for tlp_rxcpl_reorder: directed completions against a 1-cycle-latency buffer model.
module tb_tlp_rxcpl_reorder;
    localparam int TAG_W = 4, DATA_W = 32, SLOT_AW = 5, TMO_W = 16, TMO_CYC = 20;
    localparam int SLOTS = 1 << SLOT_AW;

    logic                     AvlClk_i = 1'b0;
    logic                     Rstn_i = 1'b0;
    logic                     TagIssue_i = 1'b0;
    logic                     CplReq_i = 1'b0;
    logic [TAG_W+1:0]         CplDesc_i = '0;
    logic [TAG_W+SLOT_AW-1:0] CplRdAddr_o;
    logic [DATA_W+1:0]        CplBufData_i;
    logic [DATA_W-1:0]        TxsReadData_o;
    logic                     TxsReadDataValid_o, TxsReadErr_o;
    logic                     TxsReadReady_i;
    logic                     TagRelease_o;
    logic [TAG_W-1:0]         TagReleaseId_o;
    logic                     UnexpCpl_o;
    logic [TAG_W:0]           Outstanding_o;

    tlp_rxcpl_reorder #(.TAG_W(TAG_W), .DATA_W(DATA_W), .SLOT_AW(SLOT_AW), .TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) dut (
        .AvlClk_i(AvlClk_i), .Rstn_i(Rstn_i), .TagIssue_i(TagIssue_i), .CplReq_i(CplReq_i),
        .CplDesc_i(CplDesc_i), .CplRdAddr_o(CplRdAddr_o), .CplBufData_i(CplBufData_i),
        .TxsReadData_o(TxsReadData_o), .TxsReadDataValid_o(TxsReadDataValid_o), .TxsReadErr_o(TxsReadErr_o),
        .TxsReadReady_i(TxsReadReady_i), .TagRelease_o(TagRelease_o), .TagReleaseId_o(TagReleaseId_o),
        .UnexpCpl_o(UnexpCpl_o), .Outstanding_o(Outstanding_o));

    always #5 AvlClk_i = ~AvlClk_i;

    // completion buffer model: address registered, data presented the following cycle
    logic [DATA_W+1:0]        mem [0:(1<<TAG_W)*SLOTS-1];
    logic [TAG_W+SLOT_AW-1:0] rd_addr_q = '0;
    always @(posedge AvlClk_i) rd_addr_q <= CplRdAddr_o;
    assign CplBufData_i = mem[rd_addr_q];

    int n_tests = 0, n_fail = 0, unexp_cnt = 0, cyc = 0, rdy_mode = 0;
    logic [DATA_W:0]   exp_q [$];
    int                relx [$];
    int                acc_cyc [$];
    logic              hold_vld = 1'b0;
    logic [DATA_W:0]   hold_dat = '0;

    always @(posedge AvlClk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat_dat(input int t, input int s, input int b);
        return {8'hD0, 8'(t), 8'(s), 8'(b)};
    endfunction

    task automatic tick();
        @(posedge AvlClk_i);
        #1;
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) begin
            TagIssue_i = 1'b1;
            tick();
        end
        TagIssue_i = 1'b0;
    endtask

    task automatic send_cpl(input int t, input bit last, input int nb, input int s);
        for (int b = 0; b < nb; b++) mem[t*SLOTS+b] = {(b == nb-1), 1'b0, pat_dat(t, s, b)};
        CplDesc_i = {last, 1'b1, 4'(t)};
        CplReq_i  = 1'b1;
        tick();
        CplReq_i  = 1'b0;
        tick();
    endtask

    task automatic exp_cpl(input int t, input bit last, input int nb, input int s);
        for (int b = 0; b < nb; b++) exp_q.push_back({1'b0, pat_dat(t, s, b)});
        if (last) relx.push_back(t);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || relx.size() != 0) && n < budget) begin
            @(negedge AvlClk_i);
            n++;
        end
        chk(name, 64'(exp_q.size() + relx.size()), 64'd0);
        repeat (2) tick();
    endtask

    task automatic chk_idle(input string p);
        chk({p, "_vld"}, 64'(TxsReadDataValid_o), 64'd0);
        chk({p, "_dat"}, 64'(TxsReadData_o), 64'd0);
        chk({p, "_err"}, 64'(TxsReadErr_o), 64'd0);
        chk({p, "_addr"}, 64'(CplRdAddr_o), 64'd0);
        chk({p, "_outst"}, 64'(Outstanding_o), 64'd0);
        chk({p, "_rel"}, 64'({TagRelease_o, TagReleaseId_o}), 64'd0);
        chk({p, "_unexp"}, 64'(UnexpCpl_o), 64'd0);
    endtask

    task automatic do_reset();
        Rstn_i = 1'b0;
        repeat (2) tick();
        Rstn_i = 1'b1;
        tick();
    endtask

    // sink ready: 0 = always ready, 1 = repeating 1,0,0,1 pattern, 2 = stalled
    initial begin
        logic [3:0] pat;
        int pidx;
        pat = 4'b1001;
        pidx = 0;
        TxsReadReady_i = 1'b1;
        forever begin
            @(posedge AvlClk_i);
            #1;
            case (rdy_mode)
                0: TxsReadReady_i = 1'b1;
                1: begin
                    TxsReadReady_i = pat[pidx];
                    pidx = (pidx + 1) % 4;
                end
                default: TxsReadReady_i = 1'b0;
            endcase
        end
    end

    // monitor: pops the scoreboard on every accepted beat and every release pulse
    always @(negedge AvlClk_i) begin
        if (!Rstn_i) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld && TxsReadDataValid_o) chk("hold_stable", 64'({TxsReadErr_o, TxsReadData_o}), 64'(hold_dat));
            hold_vld = TxsReadDataValid_o && !TxsReadReady_i;
            hold_dat = {TxsReadErr_o, TxsReadData_o};
            if (TxsReadDataValid_o && TxsReadReady_i) begin
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat_extra: got %0h expected no beat", {TxsReadErr_o, TxsReadData_o});
                end else begin
                    chk("beat", 64'({TxsReadErr_o, TxsReadData_o}), 64'(exp_q.pop_front()));
                end
            end
            if (TagRelease_o) begin
                if (relx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL release_extra: got id %0d expected no release", TagReleaseId_o);
                end else begin
                    chk("release_id", 64'(TagReleaseId_o), 64'(relx.pop_front()));
                end
            end
            if (UnexpCpl_o) unexp_cnt++;
        end
    end

    initial begin
        int n;
        int u0;
        for (int i = 0; i < (1<<TAG_W)*SLOTS; i++) mem[i] = '0;
        @(negedge AvlClk_i);
        chk_idle("reset");
        tick();
        Rstn_i = 1'b1;
        tick();

        // single tag, 4-beat last completion, full throughput
        acc_cyc.delete();
        issue(1);
        exp_cpl(0, 1, 4, 1);
        send_cpl(0, 1, 4, 1);
        wait_drain("t1_drain", 60);
        chk("t1_nbeats", 64'(acc_cyc.size()), 64'd4);
        if (acc_cyc.size() == 4) chk("t1_back2back", 64'(acc_cyc[3] - acc_cyc[0]), 64'd3);
        chk("t1_hol", 64'(CplRdAddr_o[TAG_W+SLOT_AW-1:SLOT_AW]), 64'd1);

        // reverse-order arrivals return in issue order
        do_reset();
        issue(3);
        for (int t = 0; t < 3; t++) exp_cpl(t, 1, 2, 2);
        for (int t = 2; t >= 0; t--) send_cpl(t, 1, 2, 2);
        wait_drain("t2_drain", 80);

        // split completion on tag3 releases only after its last part
        do_reset();
        issue(4);
        for (int t = 0; t < 3; t++) exp_cpl(t, 1, 1, 3);
        exp_cpl(3, 0, 2, 3);
        exp_cpl(3, 1, 2, 4);
        for (int t = 0; t < 3; t++) send_cpl(t, 1, 1, 3);
        send_cpl(3, 0, 2, 3);
        n = 0;
        while (exp_q.size() > 2 && n < 60) begin
            @(negedge AvlClk_i);
            n++;
        end
        chk("t3_first_part", 64'(exp_q.size()), 64'd2);
        repeat (3) tick();
        send_cpl(3, 1, 2, 4);
        wait_drain("t3_drain", 60);

        // 8 beats under toggling backpressure
        do_reset();
        rdy_mode = 1;
        acc_cyc.delete();
        issue(1);
        exp_cpl(0, 1, 8, 5);
        send_cpl(0, 1, 8, 5);
        wait_drain("t4_drain", 120);
        chk("t4_nbeats", 64'(acc_cyc.size()), 64'd8);
        rdy_mode = 0;

        // head timeout produces one error beat, then a late completion is unexpected
        do_reset();
        exp_q.push_back({1'b1, {DATA_W{1'b0}}});
        relx.push_back(0);
        issue(1);
        n = 0;
        while (!TxsReadDataValid_o && n < 60) begin
            @(negedge AvlClk_i);
            n++;
        end
        chk("t5_tmo_lat", 64'(n >= 20 && n <= 22), 64'd1);
        wait_drain("t5_drain", 20);
        u0 = unexp_cnt;
        send_cpl(0, 1, 1, 6);
        repeat (3) tick();
        chk("t5_late_unexp", 64'(unexp_cnt - u0), 64'd1);

        // fill all tags while the head is stalled, then reset mid-stream
        do_reset();
        rdy_mode = 2;
        issue(1);
        send_cpl(0, 1, 8, 7);
        issue(16);
        @(negedge AvlClk_i);
        chk("t6_outst_full", 64'(Outstanding_o), 64'd16);
        chk("t6_stall_vld", 64'(TxsReadDataValid_o), 64'd1);
        chk("t6_stall_head", 64'({TxsReadErr_o, TxsReadData_o}), 64'({1'b0, pat_dat(0, 7, 0)}));
        tick();
        Rstn_i = 1'b0;
        @(negedge AvlClk_i);
        chk_idle("t6_midrst");
        tick();
        rdy_mode = 0;
        Rstn_i = 1'b1;
        repeat (4) tick();
        chk("end_unexp_total", 64'(unexp_cnt), 64'd1);
        chk("end_queues", 64'(exp_q.size() + relx.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
